rv32i_register_file: RTL

Architectural register file for the multicycle RV32I core; the responder on the decode stage's register read interface and the target of the writeback stage's write port. It serves one registered read per cycle with a valid strobe and accepts one write per cycle. Register x0 reads as zero. On reset or on a clear request it runs a multi-cycle sweep that zeroes x1–x31. During the sweep it signals busy and returns no read data.

---
 rtl/rv32i_regfile_pkg.sv | 22 ++
 rtl/rv32i_regfile_mem.sv | 28 ++
 rtl/rv32i_register_file.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv32i_regfile_pkg.sv
// Shared types and default geometry for the RV32I architectural register file.
package rv32i_regfile_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    localparam logic [ADDR_WIDTH-1:0] X0 = '0;

    typedef enum logic {
        RfClear,
        RfIdle
    } rf_state_t;

    // Source of the held read data: hardwired zero, storage port, or captured bypass word.
    typedef enum logic [1:0] {
        SelZero,
        SelMem,
        SelBypass
    } rd_sel_t;

endpackage

// File: rtl/rv32i_regfile_mem.sv
// 1W/1R storage for x1..x(NUM_REGS-1); registered read port that holds between reads.
module rv32i_regfile_mem
    import rv32i_regfile_pkg::*;
#(
    parameter int MEM_WORD  = WORD_SIZE,
    parameter int MEM_REGS  = NUM_REGS,
    parameter int MEM_AW    = ADDR_WIDTH
) (
    input  logic                i_clk,
    input  logic                we,
    input  logic [MEM_AW-1:0]   waddr,
    input  logic [MEM_WORD-1:0] wdata,
    input  logic                re,
    input  logic [MEM_AW-1:0]   raddr,
    output logic [MEM_WORD-1:0] rdata
);

    // x0 has no storage; the top never presents address 0 on either port.
    logic [MEM_WORD-1:0] regs [1:MEM_REGS-1];

    always_ff @(posedge i_clk) begin
        if (we)
            regs[waddr] <= wdata;
        if (re)
            rdata <= regs[raddr];
    end

endmodule

// File: rtl/rv32i_register_file.sv
// RV32I register file: clearing sweep FSM, x0 masking and write-to-read bypass around the storage array.
module rv32i_register_file
    import rv32i_regfile_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_register_rst,
    input  logic                  i_register_read_en,
    input  logic [ADDR_WIDTH-1:0] i_register_addr,
    output logic                  o_register_read_valid,
    output logic [WORD_SIZE-1:0]  o_register_read_data,
    input  logic                  i_writeback_en,
    input  logic [ADDR_WIDTH-1:0] i_writeback_addr,
    input  logic [WORD_SIZE-1:0]  i_writeback_data,
    output logic                  o_busy
);

    rf_state_t             state;
    logic [ADDR_WIDTH-1:0] counter;
    rd_sel_t               rd_sel;
    logic [WORD_SIZE-1:0]  byp_data;
    logic [WORD_SIZE-1:0]  mem_rdata;

    logic                  sweep_we;
    logic                  wb_ok;
    logic                  rd_accept;
    logic                  byp_hit;
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WORD_SIZE-1:0]  mem_wdata;

    assign o_busy    = (state == RfClear);
    assign sweep_we  = !i_rst && (state == RfClear);
    assign wb_ok     = !i_rst && (state == RfIdle) && i_writeback_en && (i_writeback_addr != X0);
    assign rd_accept = !i_rst && (state == RfIdle) && !i_register_rst && i_register_read_en;
    assign byp_hit   = wb_ok && (i_writeback_addr == i_register_addr);

    assign mem_we    = sweep_we || wb_ok;
    assign mem_waddr = sweep_we ? counter : i_writeback_addr;
    assign mem_wdata = sweep_we ? '0 : i_writeback_data;
    assign mem_re    = rd_accept && (i_register_addr != X0) && !byp_hit;

    rv32i_regfile_mem #(
        .MEM_WORD (WORD_SIZE),
        .MEM_REGS (NUM_REGS),
        .MEM_AW   (ADDR_WIDTH)
    ) u_mem (
        .i_clk (i_clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (i_register_addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                 <= RfClear;
            counter               <= ADDR_WIDTH'(1);
            o_register_read_valid <= 1'b0;
            rd_sel                <= SelZero;
            byp_data              <= '0;
        end else begin
            case (state)
                RfClear: begin
                    o_register_read_valid <= 1'b0;
                    counter               <= counter + ADDR_WIDTH'(1);
                    if (counter == ADDR_WIDTH'(NUM_REGS - 1))
                        state <= RfIdle;
                end
                RfIdle: begin
                    if (i_register_rst) begin
                        state                 <= RfClear;
                        counter               <= ADDR_WIDTH'(1);
                        o_register_read_valid <= 1'b0;
                    end else begin
                        o_register_read_valid <= i_register_read_en;
                        if (i_register_read_en) begin
                            if (i_register_addr == X0)
                                rd_sel <= SelZero;
                            else if (byp_hit)
                                rd_sel <= SelBypass;
                            else
                                rd_sel <= SelMem;
                            if (byp_hit)
                                byp_data <= i_writeback_data;
                        end
                    end
                end
                default: state <= RfClear;
            endcase
        end
    end

    // Every selected source only changes on an accepted read, so the output holds between reads.
    always_comb begin
        o_register_read_data = '0;
        case (rd_sel)
            SelMem:    o_register_read_data = mem_rdata;
            SelBypass: o_register_read_data = byp_data;
            default:   o_register_read_data = '0;
        endcase
    end

endmodule
